// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
// The loader uses the slave modport. The stream source and memory model use the master modport.
interface imem_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    output s_data, s_valid,
    input  s_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: length header + big-endian words -> instruction memory, holds CPU in reset.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        cpu_rst_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK    = 3'd5;
`endif
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  logic [2:0]  state;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic [15:0] wl;
  logic [31:0] addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        accept;
  logic [15:0] len_next;
  logic        len_bad;
  logic        more_words;

  always_comb begin
    bus.s_ready  = 1'b0;
    busy         = 1'b0;
    unique case (state)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
        bus.s_ready = 1'b1;
        busy        = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        bus.s_ready = 1'b1;
        busy        = 1'b1;
      end
`endif
      ST_WRITE: busy = 1'b1;
      default: ;
    endcase
    bus.im_we    = (state == ST_WRITE);
    bus.im_addr  = addr;
    bus.im_wdata = word;
    done         = (state == ST_DONE);
    error        = (state == ST_ERROR);
    cpu_rst_hold = (state != ST_DONE);
    words_loaded = wl;
  end

  // All handshake outputs above are pure state decodes, so accept has no s_valid->s_ready loop.
  always_comb begin
    accept     = bus.s_valid && bus.s_ready;
    len_next   = {len[15:8], bus.s_data};
    len_bad    = (len_next == '0) || ({1'b0, len_next} > MAX_W);
    more_words = (({1'b0, wl} + 17'd1) < {1'b0, len});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      byte_cnt <= '0;
      word     <= '0;
      wl       <= '0;
      addr     <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state    <= ST_LEN_HI;
            wl       <= '0;
            byte_cnt <= '0;
            addr     <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.s_data;
            state     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.s_data;
            state    <= len_bad ? ST_ERROR : ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            word     <= {word[23:0], bus.s_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.s_data;
`endif
            if (byte_cnt == 2'd3)
              state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wl   <= wl + 16'd1;
          addr <= addr + 32'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
          state <= more_words ? ST_DATA : ST_CHK;
`else
          state <= more_words ? ST_DATA : ST_DONE;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (accept)
            state <= (bus.s_data == csum) ? ST_DONE : ST_ERROR;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader. It runs with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cpu_rst_hold, busy, done, error;
  logic [15:0] words_loaded;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_rst_hold (cpu_rst_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Write log: each cycle with im_we high is one recorded write.
  always @(negedge clk) begin
    if (bus.im_we) begin
      wr_addr.push_back(bus.im_addr);
      wr_data.push_back(bus.im_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. It returns at the negedge after the byte is transferred.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'd0, bus.s_ready}, 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Moves from the cycle of the last WRITE into the first DONE/ERROR cycle.
  task automatic finish_load(input logic [7:0] cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    if (cs == cs) @(negedge clk);
`endif
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    send_byte(t[31:24]);
    send_byte(t[23:16]);
    send_byte(t[15:8]);
    send_byte(t[7:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", bus.im_addr, 32'h0);
    check("rst_wdata", bus.im_wdata, 32'h0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_flags", {26'd0, cpu_rst_hold, bus.s_ready, done, bus.im_we, busy, error},
            32'b100000);
      @(negedge clk);
    end

    // Two-word load, continuous stream.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("start_ready", {31'd0, bus.s_ready}, 32'd1);
    check("start_busy", {30'd0, busy, cpu_rst_hold}, 32'b11);
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'h2008_0005);
    check("write_cycle_we_ready", {30'd0, bus.im_we, bus.s_ready}, 32'b10);
    send_word(32'hAC08_0004);
    finish_load(8'h8D);
    check("two_wr_count", wr_addr.size(), 32'd2);
    check("two_wr_addr0", wr_addr[0], 32'h0);
    check("two_wr_data0", wr_data[0], 32'h2008_0005);
    check("two_wr_addr1", wr_addr[1], 32'h4);
    check("two_wr_data1", wr_data[1], 32'hAC08_0004);
    check("two_words", {16'd0, words_loaded}, 32'd2);
    check("two_done_flags", {28'd0, done, cpu_rst_hold, busy, error}, 32'b1000);

    // Zero length.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("restart_clears", {29'd0, done, cpu_rst_hold, busy}, 32'b011);
    check("restart_words", {16'd0, words_loaded}, 32'd0);
    send_byte(8'h00); send_byte(8'h00);
    check("len0_flags", {27'd0, error, done, cpu_rst_hold, busy, bus.s_ready}, 32'b10100);
    repeat (3) @(negedge clk);
    check("len0_no_write", wr_addr.size(), 32'd0);

    // Length MAX_WORDS+1 = 257.
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    check("len257_flags", {28'd0, error, done, cpu_rst_hold, busy}, 32'b1010);
    repeat (3) @(negedge clk);
    check("len257_no_write", wr_addr.size(), 32'd0);

    // One word with s_valid toggling and a start pulse that must be ignored mid-load.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00); @(negedge clk);
    send_byte(8'h01); @(negedge clk);
    send_byte(8'h20); @(negedge clk);
    send_byte(8'h08);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("start_ignored_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00); @(negedge clk);
    send_byte(8'h05);
    check("toggle_we", {31'd0, bus.im_we}, 32'd1);
    finish_load(8'h2D);
    check("toggle_wr_count", wr_addr.size(), 32'd1);
    check("toggle_wr_addr", wr_addr[0], 32'h0);
    check("toggle_wr_data", wr_data[0], 32'h2008_0005);
    check("toggle_done", {29'd0, done, cpu_rst_hold, error}, 32'b100);
    check("toggle_words", {16'd0, words_loaded}, 32'd1);

    // Reset mid-word, then a clean one-word load.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_flags", {27'd0, cpu_rst_hold, busy, bus.s_ready, done, error}, 32'b10000);
    check("midrst_addr", bus.im_addr, 32'h0);
    check("midrst_wdata", bus.im_wdata, 32'h0);
    check("midrst_words", {16'd0, words_loaded}, 32'd0);
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'h1234_5678);
    finish_load(8'h08);
    check("midrst_wr_count", wr_addr.size(), 32'd1);
    check("midrst_wr_addr", wr_addr[0], 32'h0);
    check("midrst_wr_data", wr_data[0], 32'h1234_5678);
    check("midrst_done", {30'd0, done, cpu_rst_hold}, 32'b10);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum rejects the load and keeps the CPU in reset.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'h2008_0005);
    finish_load(8'h00);
    check("badcs_flags", {29'd0, error, done, cpu_rst_hold}, 32'b101);
    check("badcs_wr_count", wr_addr.size(), 32'd1);
    repeat (3) @(negedge clk);
    check("badcs_hold_stays", {31'd0, cpu_rst_hold}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory from a byte stream. It holds the processor in reset while loading. It accepts a length header followed by big-endian instruction words and drives the instruction-memory write port at consecutive word-aligned byte addresses. The instruction memory is read by the PC/fetch path, and this block is the writer on that same memory. When the load completes it releases the processor reset.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written; must be a multiple of 4
- MAX_WORDS, 256, largest accepted word count

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; ignored unless in IDLE, DONE or ERROR
- s_data  input  8  stream byte
- s_valid  input  1  s_data is valid
- s_ready  output  1  loader accepts a byte this cycle
- im_we  output  1  instruction-memory write strobe
- im_addr  output  32  instruction-memory byte address
- im_wdata  output  32  instruction word to write
- cpu_rst_hold  output  1  drives processor reset (OR'd with rst at top level)
- busy  output  1  a load is in progress
- done  output  1  last load completed successfully
- error  output  1  last load was rejected
- words_loaded  output  16  number of words written in the current or last load

## Operation
- Byte transfer occurs on a rising edge where s_valid && s_ready.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK (only with the macro), DONE, ERROR.
- Reset: state=IDLE; s_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_rst_hold=1, busy=0, done=0, error=0, words_loaded=0.
- IDLE/DONE/ERROR + start -> LEN_HI.
  - Clears done, error, words_loaded and the byte counter.
  - Sets im_addr=BASE_ADDR and cpu_rst_hold=1.
- LEN_HI: the accepted byte becomes len[15:8]. LEN_LO: the accepted byte becomes len[7:0].
- After LEN_LO:
  - len==0 or len>MAX_WORDS -> ERROR.
  - Otherwise -> DATA.
- DATA: accept 4 bytes, MSB first: byte0 -> word[31:24] … byte3 -> word[7:0]. After the 4th byte -> WRITE.
- WRITE (one cycle):
  - im_we=1, im_wdata=word, im_addr=BASE_ADDR+4*words_loaded.
  - On exit, words_loaded increments and im_addr advances by 4.
  - Next state: DATA if words_loaded+1 < len; otherwise CHK (macro) or DONE.
- DONE: done=1, cpu_rst_hold=0, busy=0.
- ERROR: error=1, cpu_rst_hold=1, busy=0. Memory contents already written are left as is.
- busy=1 in LEN_HI, LEN_LO, DATA, WRITE and CHK.
- s_ready=1 only in LEN_HI, LEN_LO, DATA and CHK.
- start while busy is ignored. rst in any state returns to the reset values the next cycle, including mid-word; a partial word is discarded.
- Address arithmetic is modulo 2^32. words_loaded never exceeds MAX_WORDS.

## Timing
- s_ready, im_we, busy, done, error and cpu_rst_hold are decoded from registered state only. There is no combinational path from s_valid.
- start sampled in cycle N -> s_ready=1 in cycle N+1.
- The 4th data byte accepted at edge E -> im_we=1 during the cycle after E, for exactly one cycle. s_ready=0 in that cycle.
- Minimum throughput: 5 cycles per word at continuous s_valid.
- A stall (s_valid=0) holds all state and partial data indefinitely.
- Final WRITE cycle (or accepted checksum byte) at edge E -> done=1 and cpu_rst_hold=0 from the cycle after E.
- The length error is flagged the cycle after the LEN_LO byte is accepted.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, enter CHK and accept one byte.
  - If it equals the XOR of all data bytes (header excluded) -> DONE; otherwise -> ERROR.
- Not defined: there is no CHK state. The last WRITE goes directly to DONE, and no trailing byte is consumed.

## Test plan
- Reset then idle: cpu_rst_hold=1, s_ready=0, done=0, im_we=0 for 10 cycles.
- start, then stream 00 02 | 20 08 00 05 | AC 08 00 04 at continuous s_valid:
  - Two im_we pulses: addr 0x0 with data 0x20080005, then addr 0x4 with data 0xAC080004.
  - words_loaded=2, done=1, cpu_rst_hold=0.
- Length 00 00 -> error=1, no im_we. Length MAX_WORDS+1 -> error=1, no im_we.
- Same 1-word load with s_valid toggling every other cycle -> identical write (addr 0x0) and no byte lost or duplicated.
- rst asserted after 2 of 4 data bytes, then a new 1-word load of 0x12345678 -> a single write 0x12345678 at 0x0.
- With IMEM_LOADER_CHECKSUM_EN, word 0x20080005 plus checksum 0x2D -> done=1. With checksum 0x00 -> error=1 and cpu_rst_hold stays 1.
